// File: rtl/des_ahb_pkg.sv
// Shared AHB-Lite encodings and master FSM states
// for the Triple-DES block fetch/store path.
package des_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_64      = 3'b011;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'h1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RD_HOLD,
    ST_WR_WAIT,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_DONE,
    ST_ERR
  } master_state_t;

endpackage

// File: rtl/ahb_block_master.sv
// AHB-Lite master: single read, hand-off to DES core,
// single write back, repeated per 64-bit block.
module ahb_block_master
  import des_ahb_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ADDR_INC = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [63:0]      HRDATA,
  output logic [31:0]      HADDR,
  output logic             HWRITE,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HBURST,
  output logic [2:0]       HSIZE,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [63:0]      HWDATA,
  input  logic             cmd_start,
  input  logic [31:0]      cmd_src_addr,
  input  logic [31:0]      cmd_dst_addr,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [63:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic [63:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready
);

  localparam logic [31:0] INC = 32'(ADDR_INC);

  master_state_t    state_q, state_d;
  htrans_t          htrans_q, htrans_d;
  logic [31:0]      haddr_q, haddr_d;
  logic             hwrite_q, hwrite_d;
  logic [63:0]      hwdata_q, hwdata_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [63:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_ready_q, wr_ready_d;

  logic misaligned;
  assign misaligned = (|cmd_src_addr[2:0]) |
                      (|cmd_dst_addr[2:0]);

  always_comb begin
    state_d    = state_q;
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    wr_ready_d = wr_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          src_d   = cmd_src_addr;
          dst_d   = cmd_dst_addr;
          rem_d   = cmd_count;
          error_d = 1'b0;
          if (cmd_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (misaligned) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else begin
            state_d  = ST_RD_ADDR;
            busy_d   = 1'b1;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = cmd_src_addr;
            hwrite_d = 1'b0;
          end
        end
      end
      ST_RD_ADDR: begin
        if (HREADY) begin
          state_d  = ST_RD_DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_RD_DATA: begin
        if (HRESP) begin
          state_d = ST_ERR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (HREADY) begin
          state_d    = ST_RD_HOLD;
          rd_data_d  = HRDATA;
          rd_valid_d = 1'b1;
        end
      end
      ST_RD_HOLD: begin
        if (rd_ready) begin
          state_d    = ST_WR_WAIT;
          rd_valid_d = 1'b0;
          wr_ready_d = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (wr_valid) begin
          state_d    = ST_WR_ADDR;
          wr_ready_d = 1'b0;
          hwdata_d   = wr_data;
          htrans_d   = HTRANS_NONSEQ;
          hwrite_d   = 1'b1;
          haddr_d    = dst_q;
        end
      end
      ST_WR_ADDR: begin
        if (HREADY) begin
          state_d  = ST_WR_DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (HRESP) begin
          state_d = ST_ERR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (HREADY) begin
          src_d = src_q + INC;
          dst_d = dst_q + INC;
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          if (rem_q <= 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = ST_RD_ADDR;
            htrans_d = HTRANS_NONSEQ;
            haddr_d  = src_q + INC;
            hwrite_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_q    <= ST_IDLE;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HSIZE     = HSIZE_64;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_ahb_block_master.sv
// Directed bench: AHB slave model, DES core model,
// hand-computed addresses and data per scenario.
module tb_ahb_block_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HREADY, HRESP;
  logic [63:0] HRDATA;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        cmd_start;
  logic [31:0] cmd_src_addr, cmd_dst_addr;
  logic [15:0] cmd_count;
  logic        busy, done, error;
  logic [63:0] rd_data;
  logic        rd_valid, rd_ready;
  logic [63:0] wr_data;
  logic        wr_valid, wr_ready;

  always #5 HCLK = ~HCLK;

  ahb_block_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .HADDR(HADDR),
    .HWRITE(HWRITE), .HTRANS(HTRANS),
    .HBURST(HBURST), .HSIZE(HSIZE),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA),
    .cmd_start(cmd_start),
    .cmd_src_addr(cmd_src_addr),
    .cmd_dst_addr(cmd_dst_addr),
    .cmd_count(cmd_count),
    .busy(busy), .done(done), .error(error),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave model
  int          nwait = 0;
  int          err_idx = 0;
  logic [63:0] data_base = 64'h0123456789ABCCEF;
  logic        dp_act = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  int          wait_cnt = 0;
  int          err_phase = 0;
  int          rd_n = 0;
  logic [32:0] alog [0:63];
  logic [63:0] wlog [0:63];
  int          an = 0;
  int          wn = 0;

  assign HREADY = !dp_act || err_phase == 2 ||
                  (err_phase == 0 && wait_cnt == 0);
  assign HRESP  = dp_act && err_phase != 0;
  assign HRDATA = data_base + {32'h0, dp_addr};

  always @(posedge HCLK) begin
    if (!HRESET) begin
      dp_act    <= 1'b0;
      err_phase <= 0;
      wait_cnt  <= 0;
    end else if (HREADY) begin
      if (dp_act && dp_write && err_phase == 0) begin
        wlog[wn[5:0]] <= HWDATA;
        wn <= wn + 1;
      end
      if (HTRANS == 2'b10) begin
        dp_act   <= 1'b1;
        dp_addr  <= HADDR;
        dp_write <= HWRITE;
        wait_cnt <= nwait;
        alog[an[5:0]] <= {HWRITE, HADDR};
        an <= an + 1;
        if (!HWRITE) begin
          rd_n <= rd_n + 1;
          err_phase <= (rd_n + 1 == err_idx) ? 1 : 0;
        end else begin
          err_phase <= 0;
        end
      end else begin
        dp_act    <= 1'b0;
        err_phase <= 0;
      end
    end else begin
      if (err_phase == 1) err_phase <= 2;
      else if (wait_cnt > 0) wait_cnt <= wait_cnt - 1;
    end
  end

  // DES core model
  int          rd_delay = 0;
  int          wr_delay = 0;
  logic [63:0] key = 64'h0;
  bit          have;
  int          rwait, wwait;
  logic [63:0] hold, first;

  initial begin
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 64'h0;
    have = 0; rwait = 0; wwait = 0;
    forever begin
      @(negedge HCLK);
      rd_ready = 1'b0;
      if (!HRESET) begin
        have = 0; rwait = 0; wwait = 0;
        wr_valid = 1'b0;
      end else begin
        if (wr_valid) begin
          wr_valid = 1'b0;
        end else if (have && wr_ready) begin
          if (wwait == wr_delay) begin
            wr_valid = 1'b1;
            wr_data  = hold;
            have  = 0;
            wwait = 0;
          end else begin
            wwait++;
          end
        end
        if (rd_valid && !have) begin
          if (rwait == 0) first = rd_data;
          if (rwait == rd_delay) begin
            if (rd_delay > 0)
              check("rd_stable", rd_data, first);
            rd_ready = 1'b1;
            have  = 1;
            hold  = rd_data ^ key;
            rwait = 0;
          end else begin
            rwait++;
          end
        end
      end
    end
  end

  // bus monitor
  int b2b = 0, badtr = 0, nsc = 0, errv = 0;
  bit prev_ns = 0;

  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        if (HTRANS == 2'b10 && prev_ns) b2b++;
        if (HTRANS == 2'b01 || HTRANS == 2'b11) badtr++;
        if (HTRANS == 2'b10) nsc++;
        if (dp_act && err_phase != 0 && HTRANS != 2'b00)
          errv++;
        prev_ns = (HTRANS == 2'b10);
      end else begin
        prev_ns = 0;
      end
    end
  end

  task automatic start_cmd(input logic [31:0] s,
                           input logic [31:0] d,
                           input logic [15:0] c);
    @(negedge HCLK);
    cmd_src_addr = s;
    cmd_dst_addr = d;
    cmd_count    = c;
    cmd_start    = 1'b1;
    @(negedge HCLK);
    cmd_start    = 1'b0;
  endtask

  task automatic wait_end(output bit d, output bit e);
    d = 0; e = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) d = 1;
      if (error) e = 1;
      if (d || e) break;
      @(negedge HCLK);
    end
    if (!(d || e)) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bus"},
          {18'h0, HTRANS, HADDR, HWRITE, HBURST,
           HSIZE, HPROT, HMASTLOCK},
          {18'h0, 2'b00, 32'h0, 1'b0, 3'b000,
           3'b011, 4'h1, 1'b0});
    check({tag, "_hwdata"}, HWDATA, 64'h0);
    check({tag, "_stat"},
          {59'h0, busy, done, error, rd_valid, wr_ready},
          64'h0);
    check({tag, "_rd_data"}, rd_data, 64'h0);
  endtask

  initial begin
    bit d, e;
    int a0, w0, ns0, b0, t0, e0;
    logic [63:0] t2_exp [3];
    t2_exp[0] = 64'hFEDC45677654CDEF;
    t2_exp[1] = 64'hFEDC45677654CDF7;
    t2_exp[2] = 64'hFEDC45677654CDFF;

    HRESET = 1'b0;
    cmd_start = 1'b0;
    cmd_src_addr = 32'h0;
    cmd_dst_addr = 32'h0;
    cmd_count = 16'h0;
    repeat (3) @(negedge HCLK);
    check_reset("rst");
    HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    b0 = b2b; t0 = badtr; e0 = errv;

    // single block, zero-wait, echo core
    a0 = an; w0 = wn;
    start_cmd(32'h100, 32'h200, 16'd1);
    check("t1_first_nonseq",
          {29'h0, HTRANS, HADDR, HWRITE, busy},
          {29'h0, 2'b10, 32'h100, 1'b0, 1'b1});
    wait_end(d, e);
    check("t1_de", {62'h0, d, e}, 64'b10);
    check("t1_an", 64'(an - a0), 64'd2);
    check("t1_rd", 64'(alog[a0]), {31'h0, 1'b0, 32'h100});
    check("t1_wr", 64'(alog[a0+1]), {31'h0, 1'b1, 32'h200});
    check("t1_wdata", wlog[w0], 64'h0123456789ABCDEF);
    @(negedge HCLK);
    check("t1_pulse", {62'h0, done, busy}, 64'h0);

    // three blocks, two wait states, transforming core
    nwait = 2;
    key = 64'hFFFF0000FFFF0000;
    a0 = an; w0 = wn;
    start_cmd(32'h100, 32'h200, 16'd3);
    wait_end(d, e);
    check("t2_de", {62'h0, d, e}, 64'b10);
    check("t2_an", 64'(an - a0), 64'd6);
    for (int i = 0; i < 3; i++) begin
      check("t2_rd", 64'(alog[a0+2*i]),
            {31'h0, 1'b0, 32'h100 + 32'(8*i)});
      check("t2_wr", 64'(alog[a0+2*i+1]),
            {31'h0, 1'b1, 32'h200 + 32'(8*i)});
      check("t2_wdata", wlog[w0+i], t2_exp[i]);
    end

    // error response on second read
    nwait = 0;
    err_idx = rd_n + 2;
    a0 = an; w0 = wn;
    start_cmd(32'h100, 32'h200, 16'd3);
    wait_end(d, e);
    check("t3_de", {62'h0, d, e}, 64'b01);
    repeat (3) @(negedge HCLK);
    check("t3_sticky", {62'h0, error, busy}, 64'b10);
    check("t3_an", 64'(an - a0), 64'd3);
    check("t3_rd2", 64'(alog[a0+2]), {31'h0, 1'b0, 32'h108});
    check("t3_wn", 64'(wn - w0), 64'd1);
    check("t3_idle_err", 64'(errv - e0), 64'd0);
    err_idx = 0;

    // slow core handshake
    rd_delay = 5;
    wr_delay = 4;
    key = 64'h1111111111111111;
    a0 = an; w0 = wn; ns0 = nsc;
    start_cmd(32'h100, 32'h200, 16'd1);
    wait_end(d, e);
    check("t4_de", {62'h0, d, e}, 64'b10);
    check("t4_nonseq", 64'(nsc - ns0), 64'd2);
    check("t4_wr", 64'(alog[a0+1]), {31'h0, 1'b1, 32'h200});
    check("t4_wdata", wlog[w0], 64'h1032547698BADCFE);
    rd_delay = 0;
    wr_delay = 0;
    key = 64'h0;

    // misaligned and zero-count commands
    a0 = an;
    start_cmd(32'h104, 32'h200, 16'd1);
    check("t5_src_err",
          {61'h0, error, busy, done}, 64'b100);
    check("t5_src_tr", 64'(HTRANS), 64'h0);
    start_cmd(32'h100, 32'h203, 16'd1);
    check("t5_dst_err",
          {61'h0, error, busy, done}, 64'b100);
    start_cmd(32'h100, 32'h200, 16'd0);
    check("t5_zero",
          {60'h0, done, error, busy, HTRANS != 2'b00},
          64'b1000);
    @(negedge HCLK);
    check("t5_zero_pulse", 64'(done), 64'h0);
    repeat (2) @(negedge HCLK);
    check("t5_no_bus", 64'(an - a0), 64'd0);

    // address wrap
    a0 = an; w0 = wn;
    start_cmd(32'hFFFFFFF8, 32'h300, 16'd2);
    wait_end(d, e);
    check("t6_de", {62'h0, d, e}, 64'b10);
    check("t6_rd0", 64'(alog[a0]),
          {31'h0, 1'b0, 32'hFFFFFFF8});
    check("t6_rd1", 64'(alog[a0+2]), {31'h0, 1'b0, 32'h0});
    check("t6_wr1", 64'(alog[a0+3]), {31'h0, 1'b1, 32'h308});
    check("t6_wd0", wlog[w0], 64'h0123456889ABCCE7);
    check("t6_wd1", wlog[w0+1], 64'h0123456789ABCCEF);

    // reset during write data phase
    nwait = 3;
    start_cmd(32'h400, 32'h500, 16'd1);
    d = 0;
    for (int i = 0; i < 100; i++) begin
      if (dp_act && dp_write) begin
        d = 1;
        break;
      end
      @(negedge HCLK);
    end
    check("t7_reached_wr", 64'(d), 64'd1);
    HRESET = 1'b0;
    @(negedge HCLK);
    check_reset("t7");
    HRESET = 1'b1;
    nwait = 0;
    repeat (2) @(negedge HCLK);

    check("b2b_nonseq", 64'(b2b - b0), 64'd0);
    check("busy_seq", 64'(badtr - t0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
